scsa_vl: RTL

Variable-latency, parametrised segmented carry-speculative adder. It is the successor to the fixed 16-bit, 4-bit-segment chained adder. Each segment's carry-in is speculated from the previous segment alone, and the block detects speculation errors. It either returns the approximate sum (approx mode) or spends one extra cycle producing the exact sum (exact mode). It sits between operand producers and consumers on a ready/valid interface, and keeps a saturating error counter for accuracy characterisation.

---
 rtl/scsa_vl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/scsa_vl.sv
// Segmented carry-speculative adder with variable latency. Each segment takes its
// carry-in from the previous segment evaluated with carry-in 0, and an optional FIX cycle repairs mispredictions.
module scsa_vl #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err,
  output logic             corrected,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int NSEG = WIDTH / SEG;

  typedef enum logic [1:0] {IDLE, EVAL, FIX, HOLD} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q, mode_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, err_q, corr_q;
  logic [CNT_W-1:0] cnt_q;

  // Speculative and exact datapaths, both evaluated from the captured operands.
  logic [WIDTH-1:0] spec_sum;
  logic             spec_cout;
  logic [NSEG-1:0]  mismatch;
  logic [WIDTH:0]   exact_full;
  logic [SEG:0]     seg_raw, seg_spec, seg_true;
  logic             spec_cin, prev_gen0, true_c;

  // NOTE: every variable written here gets a default first, so no latches are inferred;
  // blocking assignments are correct in combinational logic and carry values between iterations.
  always_comb begin
    spec_sum  = '0;
    spec_cout = 1'b0;
    mismatch  = '0;
    seg_raw   = '0;
    seg_spec  = '0;
    seg_true  = '0;
    spec_cin  = 1'b0;
    prev_gen0 = 1'b0;
    true_c    = cin_q;
    for (int k = 0; k < NSEG; k++) begin
      seg_raw  = {1'b0, a_q[k*SEG +: SEG]} + {1'b0, b_q[k*SEG +: SEG]};
      spec_cin = (k == 0) ? cin_q : prev_gen0;
      seg_spec = seg_raw + {{SEG{1'b0}}, spec_cin};
      seg_true = seg_raw + {{SEG{1'b0}}, true_c};
      spec_sum[k*SEG +: SEG] = seg_spec[SEG-1:0];
      if (k > 0) mismatch[k] = spec_cin ^ true_c;
      prev_gen0 = seg_raw[SEG];
      true_c    = seg_true[SEG];
      spec_cout = seg_spec[SEG];
    end
  end

  assign exact_full = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};

  logic ready_c, load_spec, load_exact, accept;

  always_comb begin
    state_d    = state_q;
    ready_c    = 1'b0;
    load_spec  = 1'b0;
    load_exact = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (in_valid) state_d = EVAL;
      end
      EVAL: begin
        if (mode_q || (mismatch == '0)) begin
          load_spec = 1'b1;
          state_d   = HOLD;
        end else begin
          state_d = FIX;
        end
      end
      FIX: begin
        load_exact = 1'b1;
        state_d    = HOLD;
      end
      HOLD: begin
        ready_c = out_ready;
        if (out_ready) state_d = in_valid ? EVAL : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = ready_c & ~rst;
  assign accept   = in_valid & in_ready;

  // NOTE: the captured operands are reset along with the control state so that
  // nothing from an aborted operation is observable after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      mode_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      corr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= a;
        b_q    <= b;
        cin_q  <= cin;
        mode_q <= mode;
      end
      if (load_spec) begin
        sum_q  <= spec_sum;
        cout_q <= spec_cout;
        err_q  <= |mismatch;
        corr_q <= 1'b0;
      end
      if (load_exact) begin
        sum_q  <= exact_full[WIDTH-1:0];
        cout_q <= exact_full[WIDTH];
        err_q  <= 1'b1;
        corr_q <= 1'b1;
      end
      // Counted once per operation, in either mode, holding at all-ones.
      if ((state_q == EVAL) && (mismatch != '0) && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;
  assign corrected = corr_q;
  assign err_cnt   = cnt_q;

endmodule
